// File: rtl/assignment_driver.sv
// Initiator for the assignment block: fires start once, then N_CALLS next calls, capturing each return bit.
// Optional stall timeout enabled by defining DRIVER_TIMEOUT_EN.
module assignment_driver #(
    parameter int unsigned N_CALLS        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               go,
    input  logic [N_CALLS-1:0] stim,
    output logic               EN_start,
    input  logic               RDY_start,
    output logic               next_k,
    output logic               EN_next,
    input  logic               next,
    input  logic               RDY_next,
    output logic [N_CALLS-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
);

    localparam int unsigned IDX_W = (N_CALLS > 1) ? $clog2(N_CALLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CALLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        NEXT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_CALLS-1:0] stim_q, stim_d;
    logic [N_CALLS-1:0] result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N_CALLS-1:0] stim_shift;

`ifdef DRIVER_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               terr_q, terr_d;
`endif

    // Method enables are gated by state so they can never fire without RDY.
    assign EN_start   = (state_q == START) & RDY_start;
    assign EN_next    = (state_q == NEXT) & RDY_next;
    assign stim_shift = stim_q >> idx_q;
    assign next_k     = (state_q == NEXT) & stim_shift[0];

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stim_d   = stim_q;
        result_d = result_q;
`ifdef DRIVER_TIMEOUT_EN
        stall_d  = '0;
        terr_d   = terr_q;
`endif

        case (state_q)
            IDLE: begin
                if (go) begin
                    stim_d   = stim;
                    result_d = '0;
                    idx_d    = '0;
`ifdef DRIVER_TIMEOUT_EN
                    terr_d   = 1'b0;
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (EN_start) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (EN_next) begin
                    result_d = (result_q & ~(N_CALLS'(1) << idx_q)) | (N_CALLS'(next) << idx_q);
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DRIVER_TIMEOUT_EN
        // Consecutive non-firing cycles while waiting on a method; abort the run at the limit.
        if (((state_q == START) && !EN_start) || ((state_q == NEXT) && !EN_next)) begin
            if (stall_q == STALL_LAST) begin
                state_d = DONE;
                terr_d  = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
`endif

        busy_d = (state_d == START) || (state_d == NEXT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            stim_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stim_q   <= stim_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef DRIVER_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            terr_q  <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    logic timeout_unused;

    assign timeout_unused = ^TIMEOUT_CYCLES;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_assignment_driver.sv
// Directed bench for assignment_driver: an N_CALLS=8 instance for the main scenarios and an N_CALLS=1 instance.
module tb_assignment_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       go;
    logic [7:0] stim;
    logic       en_start, rdy_start, next_k, en_next, next_ret, rdy_next;
    logic [7:0] result;
    logic       busy, done, timeout_err;
    logic       resp_inv;

    logic       go1;
    logic [0:0] stim1;
    logic       en_start1, next_k1, en_next1, next_ret1;
    logic [0:0] result1;
    logic       busy1, done1, terr1;

    int n_tests = 0;
    int n_fail  = 0;

    assign next_ret  = next_k ^ resp_inv;
    assign next_ret1 = next_k1;

    assignment_driver #(.N_CALLS(8), .TIMEOUT_CYCLES(16)) dut (
        .CLK(clk), .RST_N(rst_n), .go(go), .stim(stim),
        .EN_start(en_start), .RDY_start(rdy_start),
        .next_k(next_k), .EN_next(en_next), .next(next_ret), .RDY_next(rdy_next),
        .result(result), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    assignment_driver #(.N_CALLS(1), .TIMEOUT_CYCLES(16)) dut1 (
        .CLK(clk), .RST_N(rst_n), .go(go1), .stim(stim1),
        .EN_start(en_start1), .RDY_start(1'b1),
        .next_k(next_k1), .EN_next(en_next1), .next(next_ret1), .RDY_next(1'b1),
        .result(result1), .busy(busy1), .done(done1), .timeout_err(terr1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch a run and watch it until done; cycle 1 is the cycle after the go edge.
    task automatic run(input logic [7:0] s, input int mode,
                       output int done_c, output int start_c, output int n_next, output int viol);
        done_c  = -1;
        start_c = -1;
        n_next  = 0;
        viol    = 0;
        stim      = s;
        go        = 1'b1;
        rdy_start = 1'b1;
        rdy_next  = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            case (mode)
                1: begin
                    rdy_start = !(c >= 1 && c <= 3);
                    rdy_next  = !(c == 9 || c == 10);
                end
                2: begin
                    if (c == 4) begin
                        go   = 1'b1;
                        stim = 8'hFF;
                    end else begin
                        go = (c == 9 || c == 10);
                    end
                end
                3: rdy_next = (c < 4);
                default: ;
            endcase
            #1;
            if (en_start && start_c < 0) start_c = c;
            if (en_next) n_next++;
            if ((en_start && !rdy_start) || (en_next && !rdy_next)) viol++;
            if (done) begin
                done_c = c;
                break;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_c, start_c, n_next, viol, k;
        logic seen;

        rst_n = 1'b0; go = 1'b0; stim = '0; rdy_start = 1'b1; rdy_next = 1'b1;
        resp_inv = 1'b0; go1 = 1'b0; stim1 = '0;
        step();
        step();
        check("rst_en_start", en_start, 0);
        check("rst_en_next", en_next, 0);
        check("rst_next_k", next_k, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        step();

        // Always ready, inverted responder
        resp_inv = 1'b1;
        run(8'hA5, 0, done_c, start_c, n_next, viol);
        check("t1_start_cycle", start_c, 1);
        check("t1_next_count", n_next, 8);
        check("t1_done_cycle", done_c, 10);
        check("t1_result", result, 8'h5A);
        check("t1_viol", viol, 0);
        step();
        step();
        check("t1_result_hold", result, 8'h5A);
        check("t1_idle_busy", busy, 0);

        // Backpressure on both methods
        resp_inv = 1'b0;
        run(8'h3C, 1, done_c, start_c, n_next, viol);
        check("t2_start_cycle", start_c, 4);
        check("t2_next_count", n_next, 8);
        check("t2_done_cycle", done_c, 15);
        check("t2_viol", viol, 0);
        check("t2_result", result, 8'h3C);
        check("t2_timeout_err", timeout_err, 0);
        step();

        // go while busy is ignored; go held through DONE restarts
        run(8'h00, 2, done_c, start_c, n_next, viol);
        check("t3_done_cycle", done_c, 10);
        check("t3_result", result, 8'h00);
        step();
        check("t3_gap_busy", busy, 0);
        step();
        check("t3_restart_busy", busy, 1);
        go = 1'b0;
        k = 0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
            k++;
        end
        check("t3_second_done", seen, 1);
        check("t3_second_len", k, 9);
        check("t3_second_result", result, 8'hFF);
        step();

        // Reset during call 3
        resp_inv = 1'b1;
        stim = 8'hA5;
        go = 1'b1;
        step();
        go = 1'b0;
        step(); step(); step(); step();
        check("t4_call3_en", en_next, 1);
        check("t4_call3_k", next_k, 0);
        check("t4_partial", result, 8'h02);
        rst_n = 1'b0;
        step();
        check("t4_en_start", en_start, 0);
        check("t4_en_next", en_next, 0);
        check("t4_next_k", next_k, 0);
        check("t4_result", result, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        step();
        check("t4_done_late", done, 0);
        rst_n = 1'b1;
        step();
        run(8'h96, 0, done_c, start_c, n_next, viol);
        check("t4_fresh_done", done_c, 10);
        check("t4_fresh_result", result, 8'h69);
        step();

`ifdef DRIVER_TIMEOUT_EN
        // Stall after two calls
        resp_inv = 1'b0;
        run(8'hA6, 3, done_c, start_c, n_next, viol);
        check("t5_done_cycle", done_c, 20);
        check("t5_timeout_err", timeout_err, 1);
        check("t5_result", result, 8'h02);
        check("t5_next_count", n_next, 2);
        rdy_next = 1'b1;
        step();
        check("t5_err_sticky", timeout_err, 1);
        stim = 8'h11;
        go = 1'b1;
        step();
        go = 1'b0;
        check("t5_err_cleared", timeout_err, 0);
        for (int c = 0; c < 40 && !done; c++) step();
        check("t5_rerun_result", result, 8'h11);
        step();
`else
        // Without the timeout the driver waits indefinitely
        resp_inv = 1'b0;
        stim = 8'h01;
        go = 1'b1;
        step();
        go = 1'b0;
        rdy_next = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("t5_no_done", seen, 0);
        check("t5_still_busy", busy, 1);
        check("t5_no_en_next", en_next, 0);
        check("t5_no_err", timeout_err, 0);
        rdy_next = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("t5_resume_done", seen, 1);
        check("t5_resume_result", result, 8'h01);
        step();
`endif

        // N_CALLS = 1 boundary
        stim1 = 1'b1;
        go1 = 1'b1;
        step();
        go1 = 1'b0;
        check("t6_en_start", en_start1, 1);
        step();
        check("t6_en_next", en_next1, 1);
        check("t6_next_k", next_k1, 1);
        step();
        check("t6_done", done1, 1);
        check("t6_result", result1, 1);
        check("t6_terr", terr1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
